wb_retire_trace: RTL and testbench
==================================

# wb_retire_trace

Write-back retirement trace buffer that sits directly downstream of the pipelined MIPS processor's MEM/WB stage. It samples every architectural register write leaving the pipeline, discards writes to `$0`, and stamps each event with a cycle count. It queues the events in a show-ahead FIFO and presents them on a valid/ready port to the trace/checker logic. Drops caused by back-pressure are counted and flagged, so no lost retirement passes unnoticed.

## Interface
Parameters:
- `DEPTH`, 16: FIFO entries; power of two, minimum 2.
- `CYC_W`, 16: width of the cycle stamp.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `wb_RegWrite`  in  1  MEM/WB RegWrite control signal.
- `wb_MemtoReg`  in  1  MEM/WB MemtoReg control signal; 1 selects memory data.
- `wb_RegDstOutput`  in  5  MEM/WB destination register number.
- `wb_DataMemoryOutput`  in  32  MEM/WB data-memory result.
- `wb_MainALUOutput`  in  32  MEM/WB ALU result.
- `flush`  in  1  synchronous clear of the FIFO and the error state.
- `trace_ready`  in  1  consumer accepts the head entry.
- `trace_valid`  out  1  head entry present.
- `trace_reg`  out  5  head entry destination register.
- `trace_data`  out  32  head entry write data.
- `trace_src`  out  1  head entry source: 1 is memory, 0 is ALU.
- `trace_cycle`  out  CYC_W  head entry cycle stamp.
- `count`  out  log2(DEPTH)+1  occupancy, 0..DEPTH.
- `full`  out  1  count == DEPTH.
- `empty`  out  1  count == 0.
- `overflow`  out  1  sticky flag, set on any drop.
- `drop_count`  out  16  saturating count of dropped events.

## Operation
- **Cycle counter:**
  - Free-running, CYC_W bits.
  - Increments every clock and wraps from all-ones to 0.
  - Not affected by `flush`.
- **Event (push request):** `wb_RegWrite == 1 && wb_RegDstOutput != 0`, sampled at the rising edge.
  - `wb_RegDstOutput == 0` is never queued and never counted as a drop.
- **Entry contents:**
  - reg = `wb_RegDstOutput`.
  - data = `wb_MemtoReg ? wb_DataMemoryOutput : wb_MainALUOutput`.
  - src = `wb_MemtoReg`.
  - cycle = counter value at the sampling edge, before the increment.
- **FIFO structure:**
  - Circular buffer with read and write pointers of log2(DEPTH) bits that wrap naturally.
  - Occupancy is held in a separate `count` register.
- **Pop:** occurs when `trace_valid && trace_ready`. `trace_ready` while empty has no effect.
- **Push/pop resolution, one edge:**
  - Not full: push accepted.
  - Full with pop in the same cycle: push accepted; `count` stays at DEPTH; the freed slot is reused.
  - Full without pop: push dropped; `overflow` is set; `drop_count` increments, saturating at 0xFFFF.
  - Push and pop both accepted at any occupancy: `count` is unchanged.
- **Flush:** has priority over everything in the same cycle.
  - Pointers and `count` go to 0; `overflow` and `drop_count` go to 0.
  - A coincident push or pop is discarded and is not counted as a drop.
- **Head outputs:**
  - Show-ahead: `trace_*` reflect the entry at the read pointer whenever `trace_valid` is 1.
  - When empty they hold 0.

## Timing
- **Reset (asynchronous, `reset == 0`):**
  - Cycle counter, pointers, `count`, `overflow` and `drop_count` are 0.
  - `trace_valid` = 0, `trace_reg`/`trace_data`/`trace_src`/`trace_cycle` = 0, `empty` = 1, `full` = 0.
- **Reset mid-operation:** all queued entries are lost, with no drop accounting. The first edge after `reset` returns high samples the cycle stamp as 0.
- **Latency:** an event sampled at edge N into an empty FIFO gives `trace_valid = 1` after edge N. It is consumed at edge N+1 if `trace_ready` is high.
- **Throughput:** one push and one pop per cycle sustained, no bubbles.
- `full`, `empty` and `count` are registered-consistent: they update on the same edge as the pointers.
- `trace_ready` may depend combinationally on `trace_valid`. `trace_valid` never depends combinationally on `trace_ready`.
- **Pipeline stalls:** the processor holds the MEM/WB register stable for several cycles during a stall. Each cycle with an active event is a distinct push. This is by design: the trace reflects the WB-port activity seen on each cycle.

## Test plan
- Reset, then one event: RegWrite=1, RegDst=8, MemtoReg=0, ALU=0x0000002A at the edge with cycle=3.
  - Required: after that edge, `trace_valid`=1, `trace_reg`=8, `trace_data`=0x2A, `trace_src`=0, `trace_cycle`=3, `count`=1.
- Event with RegDst=0 and RegWrite=1, then an event with MemtoReg=1, RegDst=9, mem=0xDEADBEEF.
  - Required: only one entry is queued: reg 9, data 0xDEADBEEF, src 1. `drop_count` stays 0.
- `trace_ready`=0 with DEPTH+3 consecutive events (regs 1..19).
  - Required: `full`=1 and `count`=16; `overflow`=1 and `drop_count`=3.
  - Draining returns regs 1..16 in order, with cycle stamps strictly consecutive.
- With the FIFO full, push and pop on the same edge.
  - Required: `count` stays 16, no drop, and the new entry appears after the 15 remaining older entries.
- Flush asserted with count=5 and a coincident event.
  - Required: `count`=0, `empty`=1, `overflow`=0, `drop_count`=0 on the next cycle, and the cycle counter continues uninterrupted.
- Assert `reset` low asynchronously mid-drain with count=4.
  - Required: outputs go to their reset values immediately, without waiting for a clock edge.
  - The first event after release is stamped cycle 0.

Source files
------------

// File: rtl/wb_retire_trace.sv
// Retirement trace buffer: captures non-$0 register writes from MEM/WB, stamps them
// with a free-running cycle count and queues them in a show-ahead FIFO with drop accounting.
module wb_retire_trace #(
    parameter int DEPTH = 16,
    parameter int CYC_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wb_RegWrite,
    input  logic                     wb_MemtoReg,
    input  logic [4:0]               wb_RegDstOutput,
    input  logic [31:0]              wb_DataMemoryOutput,
    input  logic [31:0]              wb_MainALUOutput,
    input  logic                     flush,
    input  logic                     trace_ready,
    output logic                     trace_valid,
    output logic [4:0]               trace_reg,
    output logic [31:0]              trace_data,
    output logic                     trace_src,
    output logic [CYC_W-1:0]         trace_cycle,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow,
    output logic [15:0]              drop_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [4:0]       rd;
        logic [31:0]      data;
        logic             src;
        logic [CYC_W-1:0] cyc;
    } entry_t;

    entry_t           r_mem [DEPTH];
    logic [CYC_W-1:0] r_cyc;
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             r_overflow;
    logic [15:0]      r_drop;

    logic   w_push_req;
    logic   w_full;
    logic   w_valid;
    logic   w_pop;
    logic   w_push_ok;
    logic   w_drop;
    entry_t w_new;
    entry_t w_head;

    // A freed slot at full occupancy is reusable on the same edge, so a pop rescues the push.
    assign w_push_req = wb_RegWrite && (wb_RegDstOutput != 5'd0);
    assign w_full     = (r_count == CNT_W'(DEPTH));
    assign w_valid    = (r_count != {CNT_W{1'b0}});
    assign w_pop      = w_valid && trace_ready;
    assign w_push_ok  = w_push_req && (!w_full || w_pop);
    assign w_drop     = w_push_req && w_full && !w_pop;

    assign w_new.rd   = wb_RegDstOutput;
    assign w_new.data = wb_MemtoReg ? wb_DataMemoryOutput : wb_MainALUOutput;
    assign w_new.src  = wb_MemtoReg;
    assign w_new.cyc  = r_cyc;

    // Free-running cycle stamp; deliberately untouched by flush.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cyc <= {CYC_W{1'b0}};
        end else begin
            r_cyc <= r_cyc + CYC_W'(1);
        end
    end

    // Entry storage; contents need no reset because the head is gated by occupancy.
    always_ff @(posedge clk) begin
        if (w_push_ok && !flush) begin
            r_mem[r_wptr] <= w_new;
        end
    end

    // Pointers and occupancy; flush acts as the synchronous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr  <= {PTR_W{1'b0}};
            r_rptr  <= {PTR_W{1'b0}};
            r_count <= {CNT_W{1'b0}};
        end else if (flush) begin
            r_wptr  <= {PTR_W{1'b0}};
            r_rptr  <= {PTR_W{1'b0}};
            r_count <= {CNT_W{1'b0}};
        end else begin
            if (w_push_ok) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            if (w_push_ok && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_push_ok && w_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    // Drop accounting: sticky flag plus a counter that saturates instead of wrapping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_overflow <= 1'b0;
            r_drop     <= 16'd0;
        end else if (flush) begin
            r_overflow <= 1'b0;
            r_drop     <= 16'd0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop != 16'hFFFF) begin
                r_drop <= r_drop + 16'd1;
            end
        end
    end

    // Show-ahead head view, forced to zero whenever the queue is empty.
    always_comb begin
        w_head = '{rd: 5'd0, data: 32'd0, src: 1'b0, cyc: {CYC_W{1'b0}}};
        if (w_valid) begin
            w_head = r_mem[r_rptr];
        end else begin
            w_head = '{rd: 5'd0, data: 32'd0, src: 1'b0, cyc: {CYC_W{1'b0}}};
        end
    end

    assign trace_valid = w_valid;
    assign trace_reg   = w_head.rd;
    assign trace_data  = w_head.data;
    assign trace_src   = w_head.src;
    assign trace_cycle = w_head.cyc;
    assign count       = r_count;
    assign full        = w_full;
    assign empty       = !w_valid;
    assign overflow    = r_overflow;
    assign drop_count  = r_drop;

endmodule

// File: tb/tb_wb_retire_trace.sv
// Scoreboard bench for wb_retire_trace: expected entries are queued as events are driven
// and compared against the head as the DUT presents them.
module tb_wb_retire_trace;

    localparam int DEPTH = 16;
    localparam int CYC_W = 16;

    logic        clk;
    logic        reset;
    logic        wb_RegWrite;
    logic        wb_MemtoReg;
    logic [4:0]  wb_RegDstOutput;
    logic [31:0] wb_DataMemoryOutput;
    logic [31:0] wb_MainALUOutput;
    logic        flush;
    logic        trace_ready;
    logic        trace_valid;
    logic [4:0]  trace_reg;
    logic [31:0] trace_data;
    logic        trace_src;
    logic [15:0] trace_cycle;
    logic [4:0]  count;
    logic        full;
    logic        empty;
    logic        overflow;
    logic [15:0] drop_count;

    typedef struct packed {
        logic [4:0]  r;
        logic [31:0] d;
        logic        s;
        logic [15:0] c;
    } ent_t;

    ent_t        sb_q[$];
    logic [15:0] m_cyc;
    logic [15:0] m_drop;
    logic        m_ovf;
    int          n_tests;
    int          n_fail;
    logic [4:0]  last_pop_reg;
    logic [15:0] last_pop_cyc;
    logic [15:0] prev_cyc;
    logic [15:0] c0;

    wb_retire_trace #(.DEPTH(DEPTH), .CYC_W(CYC_W)) dut (
        .clk                 (clk),
        .reset               (reset),
        .wb_RegWrite         (wb_RegWrite),
        .wb_MemtoReg         (wb_MemtoReg),
        .wb_RegDstOutput     (wb_RegDstOutput),
        .wb_DataMemoryOutput (wb_DataMemoryOutput),
        .wb_MainALUOutput    (wb_MainALUOutput),
        .flush               (flush),
        .trace_ready         (trace_ready),
        .trace_valid         (trace_valid),
        .trace_reg           (trace_reg),
        .trace_data          (trace_data),
        .trace_src           (trace_src),
        .trace_cycle         (trace_cycle),
        .count               (count),
        .full                (full),
        .empty               (empty),
        .overflow            (overflow),
        .drop_count          (drop_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference cycle counter: value read between edges is the stamp of the next edge.
    always @(posedge clk or negedge reset) begin
        if (!reset) m_cyc <= 16'd0;
        else        m_cyc <= m_cyc + 16'd1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, "_count"}, 64'(count), 64'(sb_q.size()));
        check({tag, "_full"}, 64'(full), 64'(sb_q.size() == DEPTH));
        check({tag, "_empty"}, 64'(empty), 64'(sb_q.size() == 0));
        check({tag, "_ovf"}, 64'(overflow), 64'(m_ovf));
        check({tag, "_drop"}, 64'(drop_count), 64'(m_drop));
        if (sb_q.size() != 0) begin
            check({tag, "_valid"}, 64'(trace_valid), 64'd1);
            check({tag, "_reg"}, 64'(trace_reg), 64'(sb_q[0].r));
            check({tag, "_data"}, 64'(trace_data), 64'(sb_q[0].d));
            check({tag, "_src"}, 64'(trace_src), 64'(sb_q[0].s));
            check({tag, "_cyc"}, 64'(trace_cycle), 64'(sb_q[0].c));
        end else begin
            check({tag, "_valid"}, 64'(trace_valid), 64'd0);
            check({tag, "_head0"}, {27'd0, trace_reg, trace_data}, 64'd0);
            check({tag, "_hsrc0"}, {47'd0, trace_src, trace_cycle}, 64'd0);
        end
    endtask

    // One clock: drive inputs after a falling edge, update the model, compare at the next falling edge.
    task automatic tick(input string tag, input logic we, input logic [4:0] rd, input logic m2r,
                        input logic [31:0] mem, input logic [31:0] alu, input logic rdy, input logic fl);
        logic pop;
        logic was_full;
        ent_t e;
        wb_RegWrite         = we;
        wb_RegDstOutput     = rd;
        wb_MemtoReg         = m2r;
        wb_DataMemoryOutput = mem;
        wb_MainALUOutput    = alu;
        trace_ready         = rdy;
        flush               = fl;
        pop      = (sb_q.size() != 0) && rdy;
        was_full = (sb_q.size() == DEPTH);
        if (pop) begin
            last_pop_reg = trace_reg;
            last_pop_cyc = trace_cycle;
        end
        if (fl) begin
            sb_q.delete();
            m_ovf  = 1'b0;
            m_drop = 16'd0;
        end else begin
            if (pop) void'(sb_q.pop_front());
            if (we && rd != 5'd0) begin
                if (!was_full || pop) begin
                    e.r = rd;
                    e.d = m2r ? mem : alu;
                    e.s = m2r;
                    e.c = m_cyc;
                    sb_q.push_back(e);
                end else begin
                    m_ovf = 1'b1;
                    if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        check_state(tag);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        m_drop  = 16'd0;
        m_ovf   = 1'b0;
        reset = 1'b0;
        wb_RegWrite = 1'b0; wb_MemtoReg = 1'b0; wb_RegDstOutput = 5'd0;
        wb_DataMemoryOutput = 32'd0; wb_MainALUOutput = 32'd0;
        flush = 1'b0; trace_ready = 1'b0;
        last_pop_reg = 5'd0; last_pop_cyc = 16'd0; prev_cyc = 16'd0; c0 = 16'd0;

        repeat (2) @(negedge clk);
        check_state("rst");
        reset = 1'b1;

        // Single ALU event stamped at cycle 3
        repeat (3) tick("idle", 1'b0, 5'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        tick("ev1", 1'b1, 5'd8, 1'b0, 32'h1111_1111, 32'h0000_002A, 1'b0, 1'b0);
        check("t1_valid", 64'(trace_valid), 64'd1);
        check("t1_reg", 64'(trace_reg), 64'd8);
        check("t1_data", 64'(trace_data), 64'h2A);
        check("t1_src", 64'(trace_src), 64'd0);
        check("t1_cyc", 64'(trace_cycle), 64'd3);
        check("t1_count", 64'(count), 64'd1);
        tick("drain1", 1'b0, 5'd0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0);

        // $0 write ignored, memory-sourced write queued
        tick("r0", 1'b1, 5'd0, 1'b0, 32'd0, 32'h5555_5555, 1'b0, 1'b0);
        tick("mem9", 1'b1, 5'd9, 1'b1, 32'hDEAD_BEEF, 32'h0000_0077, 1'b0, 1'b0);
        check("t2_count", 64'(count), 64'd1);
        check("t2_reg", 64'(trace_reg), 64'd9);
        check("t2_data", 64'(trace_data), 64'hDEAD_BEEF);
        check("t2_src", 64'(trace_src), 64'd1);
        check("t2_drop", 64'(drop_count), 64'd0);
        tick("drain2", 1'b0, 5'd0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0);

        // Overfill with DEPTH+3 events
        for (int i = 1; i <= DEPTH + 3; i++) begin
            tick("fill", 1'b1, 5'(i), i[0], 32'hA000_0000 | 32'(i), 32'h0000_1000 | 32'(i), 1'b0, 1'b0);
        end
        check("t3_full", 64'(full), 64'd1);
        check("t3_count", 64'(count), 64'd16);
        check("t3_ovf", 64'(overflow), 64'd1);
        check("t3_drop", 64'(drop_count), 64'd3);

        // Push and pop together at full
        tick("fullpp", 1'b1, 5'd20, 1'b0, 32'd0, 32'h0000_1400, 1'b1, 1'b0);
        check("t4_count", 64'(count), 64'd16);
        check("t4_drop", 64'(drop_count), 64'd3);
        check("t4_popreg", 64'(last_pop_reg), 64'd1);
        prev_cyc = last_pop_cyc;
        for (int i = 0; i < DEPTH; i++) begin
            tick("drain3", 1'b0, 5'd0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
            if (last_pop_reg >= 5'd2 && last_pop_reg <= 5'd16) begin
                check("consec", 64'(last_pop_cyc), 64'(16'(prev_cyc + 16'd1)));
                prev_cyc = last_pop_cyc;
            end
        end
        check("t4_last", 64'(last_pop_reg), 64'd20);

        // Flush at count 5 with a coincident event; overflow still set from the overfill
        for (int i = 21; i <= 25; i++) begin
            tick("pre_fl", 1'b1, 5'(i), 1'b0, 32'd0, 32'(i * 3), 1'b0, 1'b0);
        end
        c0 = m_cyc;
        tick("flush", 1'b1, 5'd26, 1'b0, 32'd0, 32'h0000_0026, 1'b1, 1'b1);
        check("t5_count", 64'(count), 64'd0);
        check("t5_empty", 64'(empty), 64'd1);
        check("t5_ovf", 64'(overflow), 64'd0);
        check("t5_drop", 64'(drop_count), 64'd0);
        tick("post_fl", 1'b1, 5'd27, 1'b1, 32'h0BAD_F00D, 32'd0, 1'b0, 1'b0);
        check("t5_cyc", 64'(trace_cycle), 64'(16'(c0 + 16'd1)));
        tick("drain4", 1'b0, 5'd0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0);

        // Asynchronous reset mid-drain at count 4
        for (int i = 1; i <= 5; i++) begin
            tick("pre_rst", 1'b1, 5'(i), 1'b1, 32'hC000_0000 + 32'(i), 32'd0, 1'b0, 1'b0);
        end
        tick("mid", 1'b0, 5'd0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        check("t6_count4", 64'(count), 64'd4);
        #2;
        reset = 1'b0;
        #1;
        sb_q.delete();
        m_ovf  = 1'b0;
        m_drop = 16'd0;
        check("t6_valid", 64'(trace_valid), 64'd0);
        check("t6_count", 64'(count), 64'd0);
        check("t6_empty", 64'(empty), 64'd1);
        check("t6_full", 64'(full), 64'd0);
        check("t6_head", {27'd0, trace_reg, trace_data}, 64'd0);
        check("t6_hsrc", {47'd0, trace_src, trace_cycle}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        tick("after_rst", 1'b1, 5'd7, 1'b0, 32'd0, 32'h0000_0707, 1'b0, 1'b0);
        check("t6_cyc0", 64'(trace_cycle), 64'd0);
        check("t6_reg", 64'(trace_reg), 64'd7);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
